// File: rtl/mc_pkg.sv
// Shared constants for the Lab3 multicycle datapath: opcodes, ALU function
// codes, ALU B operand select encodings and instruction field positions.
package mc_pkg;

    localparam int RF_AW = 5;

    // Instruction opcodes (IR[31:26]); the control FSM also drives these on ALU_Opcode.
    localparam logic [5:0] OP_MOV  = 6'h10;
    localparam logic [5:0] OP_ADD  = 6'h12;
    localparam logic [5:0] OP_SUB  = 6'h13;
    localparam logic [5:0] OP_OR   = 6'h14;
    localparam logic [5:0] OP_AND  = 6'h15;
    localparam logic [5:0] OP_BEQ  = 6'h20;
    localparam logic [5:0] OP_ADDI = 6'h32;
    localparam logic [5:0] OP_SUBI = 6'h33;
    localparam logic [5:0] OP_ORI  = 6'h34;
    localparam logic [5:0] OP_ANDI = 6'h35;
    localparam logic [5:0] OP_LI   = 6'h39;
    localparam logic [5:0] OP_LWI  = 6'h3B;
    localparam logic [5:0] OP_SWI  = 6'h3C;

    // ALU function, taken from the low nibble of ALU_Opcode (BEQ compare is special-cased).
    localparam logic [3:0] ALU_PASS_A = 4'h0;
    localparam logic [3:0] ALU_ADD    = 4'h2;
    localparam logic [3:0] ALU_SUB    = 4'h3;
    localparam logic [3:0] ALU_OR     = 4'h4;
    localparam logic [3:0] ALU_AND    = 4'h5;
    localparam logic [3:0] ALU_PASS_B = 4'h9;
    localparam logic [3:0] ALU_LWI    = 4'hB;
    localparam logic [3:0] ALU_SWI    = 4'hC;

    typedef enum logic [1:0] {
        ALUB_B_REG    = 2'd0,
        ALUB_ONE      = 2'd1,
        ALUB_SEXT_IMM = 2'd2,
        ALUB_ZEXT_IMM = 2'd3
    } alub_sel_e;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/mc_datapath_if.sv
// Unified instruction/data memory port of the multicycle datapath.
// The datapath is the master; the memory answers combinationally.
interface mc_datapath_if #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 8
);
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/mc_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, sync clear.
// Build option MC_DP_R0_ZERO_EN makes register 0 a hardwired zero.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RF_AW-1:0]  raddr_a,
    input  logic [RF_AW-1:0]  raddr_b,
    input  logic              we,
    input  logic [RF_AW-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [NREG-1:0][DATA_W-1:0] regs;
    logic                        wr_ok;

`ifdef MC_DP_R0_ZERO_EN
    assign wr_ok   = we && (waddr != '0);
    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
`else
    assign wr_ok   = we;
    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
`endif

    // Reads see the flop outputs, so a same-cycle write to the read address returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath for the Lab3 processor: PC/IR/MDR/A/B/ALUOut, register file, inline ALU.
// Build option MC_DP_R0_ZERO_EN (in mc_regfile) makes register 0 read as zero.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 8,
    parameter int NREG       = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [5:0]        OP_Code,
    input  logic              MemWrite,
    input  logic              PC_Reg_Write,
    input  logic              PC_Reg_Write_BEQ,
    input  logic              Instruction_Reg_Write,
    input  logic              Memory_Data_Reg_Write,
    input  logic              A_Reg_Write,
    input  logic              B_Reg_Write,
    input  logic              ALU_Op_Reg_Write,
    input  logic              Register_File_Write,
    input  logic              IorD_Mux_Select,
    input  logic              Reg_File_B_Mux_Select,
    input  logic              Write_Data_Mux_Select,
    input  logic              ALU_A_Mux_Select,
    input  logic              PC_Source_Mux_Select,
    input  logic [1:0]        ALU_B_Mux_Select,
    input  logic [5:0]        ALU_Opcode,
    mc_datapath_if.master     bus,
    output logic              zero
);
    logic [MEM_ADDR_W-1:0] pc, pc_next;
    logic [DATA_W-1:0]     ir, mdr, a_reg, b_reg, alu_out;
    logic [DATA_W-1:0]     alu_a, alu_b, alu_res;
    logic [DATA_W-1:0]     rf_rdata_a, rf_rdata_b, rf_wdata;
    logic [DATA_W-1:0]     imm_sext, imm_zext;
    logic [RF_AW-1:0]      rd, rs, rt, rf_raddr_b;
    logic [15:0]           imm;
    logic                  pc_en;

    assign OP_Code = ir[OP_MSB:OP_LSB];
    assign rd      = ir[RD_MSB:RD_LSB];
    assign rs      = ir[RS_MSB:RS_LSB];
    assign rt      = ir[RT_MSB:RT_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];

    assign imm_sext   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext   = {{(DATA_W-16){1'b0}}, imm};
    assign rf_raddr_b = Reg_File_B_Mux_Select ? rd : rt;
    assign rf_wdata   = Write_Data_Mux_Select ? mdr : alu_out;

    mc_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rs),
        .raddr_b (rf_raddr_b),
        .we      (Register_File_Write),
        .waddr   (rd),
        .wdata   (rf_wdata),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    assign alu_a = ALU_A_Mux_Select ? DATA_W'(pc) : a_reg;

    always_comb begin
        alu_b = b_reg;
        case (alub_sel_e'(ALU_B_Mux_Select))
            ALUB_B_REG:    alu_b = b_reg;
            ALUB_ONE:      alu_b = DATA_W'(1);
            ALUB_SEXT_IMM: alu_b = imm_sext;
            ALUB_ZEXT_IMM: alu_b = imm_zext;
        endcase
    end

    // The BEQ compare shares the low nibble with pass-A, so it is matched on the full code first.
    always_comb begin
        alu_res = '0;
        if (ALU_Opcode == OP_BEQ) begin
            alu_res = alu_a - alu_b;
        end else begin
            case (ALU_Opcode[3:0])
                ALU_PASS_A:                 alu_res = alu_a;
                ALU_ADD, ALU_LWI, ALU_SWI:  alu_res = alu_a + alu_b;
                ALU_SUB:                    alu_res = alu_a - alu_b;
                ALU_OR:                     alu_res = alu_a | alu_b;
                ALU_AND:                    alu_res = alu_a & alu_b;
                ALU_PASS_B:                 alu_res = alu_b;
                default:                    alu_res = '0;
            endcase
        end
    end

    assign zero    = (alu_res == '0);
    assign pc_en   = PC_Reg_Write | (PC_Reg_Write_BEQ & zero);
    assign pc_next = PC_Source_Mux_Select ? alu_out[MEM_ADDR_W-1:0] : alu_res[MEM_ADDR_W-1:0];

    assign bus.mem_addr  = IorD_Mux_Select ? alu_out[MEM_ADDR_W-1:0] : pc;
    assign bus.mem_wdata = b_reg;
    assign bus.mem_we    = MemWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
        end else begin
            if (pc_en)                 pc      <= pc_next;
            if (Instruction_Reg_Write) ir      <= bus.mem_rdata;
            if (Memory_Data_Reg_Write) mdr     <= bus.mem_rdata;
            if (A_Reg_Write)           a_reg   <= rf_rdata_a;
            if (B_Reg_Write)           b_reg   <= rf_rdata_b;
            if (ALU_Op_Reg_Write)      alu_out <= alu_res;
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed instruction sequences, an ALU vector
// table, and randomized strobes checked every cycle against a behavioural model.
module tb_mc_datapath;
    import mc_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP_Code;
    logic       MemWrite, PC_Reg_Write, PC_Reg_Write_BEQ, Instruction_Reg_Write;
    logic       Memory_Data_Reg_Write, A_Reg_Write, B_Reg_Write, ALU_Op_Reg_Write;
    logic       Register_File_Write, IorD_Mux_Select, Reg_File_B_Mux_Select;
    logic       Write_Data_Mux_Select, ALU_A_Mux_Select, PC_Source_Mux_Select;
    logic [1:0] ALU_B_Mux_Select;
    logic [5:0] ALU_Opcode;
    logic       zero;

    always #5 clk = ~clk;

    mc_datapath_if #(.DATA_W(DW), .MEM_ADDR_W(AW)) bus ();

    mc_datapath #(.DATA_W(DW), .MEM_ADDR_W(AW), .NREG(32)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .OP_Code               (OP_Code),
        .MemWrite              (MemWrite),
        .PC_Reg_Write          (PC_Reg_Write),
        .PC_Reg_Write_BEQ      (PC_Reg_Write_BEQ),
        .Instruction_Reg_Write (Instruction_Reg_Write),
        .Memory_Data_Reg_Write (Memory_Data_Reg_Write),
        .A_Reg_Write           (A_Reg_Write),
        .B_Reg_Write           (B_Reg_Write),
        .ALU_Op_Reg_Write      (ALU_Op_Reg_Write),
        .Register_File_Write   (Register_File_Write),
        .IorD_Mux_Select       (IorD_Mux_Select),
        .Reg_File_B_Mux_Select (Reg_File_B_Mux_Select),
        .Write_Data_Mux_Select (Write_Data_Mux_Select),
        .ALU_A_Mux_Select      (ALU_A_Mux_Select),
        .PC_Source_Mux_Select  (PC_Source_Mux_Select),
        .ALU_B_Mux_Select      (ALU_B_Mux_Select),
        .ALU_Opcode            (ALU_Opcode),
        .bus                   (bus),
        .zero                  (zero)
    );

    typedef struct packed {
        logic       mem_write, pc_w, pc_beq, ir_w, mdr_w, a_w, b_w, aluout_w, rf_w;
        logic       iord, rfb, wd, alua, pcsrc;
        logic [1:0] alub;
        logic [5:0] aluop;
    } ctrl_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [31:0] m_rf [32];
    logic [7:0]  m_pc;
    logic [31:0] m_ir, m_mdr, m_a, m_b, m_alu_out;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 6'h20) return a - b;
        case (op[3:0])
            4'h0:             return a;
            4'h2, 4'hB, 4'hC: return a + b;
            4'h3:             return a - b;
            4'h4:             return a | b;
            4'h5:             return a & b;
            4'h9:             return b;
            default:          return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] rf_rd(input logic [4:0] r);
`ifdef MC_DP_R0_ZERO_EN
        if (r == 5'd0) return 32'h0;
`endif
        return m_rf[r];
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'h0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input ctrl_t c);
        MemWrite              = c.mem_write;
        PC_Reg_Write          = c.pc_w;
        PC_Reg_Write_BEQ      = c.pc_beq;
        Instruction_Reg_Write = c.ir_w;
        Memory_Data_Reg_Write = c.mdr_w;
        A_Reg_Write           = c.a_w;
        B_Reg_Write           = c.b_w;
        ALU_Op_Reg_Write      = c.aluout_w;
        Register_File_Write   = c.rf_w;
        IorD_Mux_Select       = c.iord;
        Reg_File_B_Mux_Select = c.rfb;
        Write_Data_Mux_Select = c.wd;
        ALU_A_Mux_Select      = c.alua;
        PC_Source_Mux_Select  = c.pcsrc;
        ALU_B_Mux_Select      = c.alub;
        ALU_Opcode            = c.aluop;
    endtask

    // One clock: apply inputs, compare outputs with the model mid-cycle, then advance the model.
    task automatic tick(input ctrl_t c, input logic [31:0] rdata, input logic rst);
        logic [31:0] opa, opb, res, va, vb, wdat;
        logic [4:0]  rd, rs, pb;
        drive(c);
        bus.mem_rdata = rdata;
        reset = rst;
        opa = c.alua ? {24'h0, m_pc} : m_a;
        case (c.alub)
            2'd0: opb = m_b;
            2'd1: opb = 32'd1;
            2'd2: opb = {{16{m_ir[15]}}, m_ir[15:0]};
            default: opb = {16'h0, m_ir[15:0]};
        endcase
        res = ref_alu(c.aluop, opa, opb);
        @(negedge clk);
        check("op_code",   {26'h0, OP_Code},       {26'h0, m_ir[31:26]});
        check("mem_addr",  {24'h0, bus.mem_addr},  {24'h0, c.iord ? m_alu_out[7:0] : m_pc});
        check("mem_wdata", bus.mem_wdata,          m_b);
        check("mem_we",    {31'h0, bus.mem_we},    {31'h0, c.mem_write});
        check("zero",      {31'h0, zero},          {31'h0, res == 32'h0});
        @(posedge clk);
        if (rst) begin
            m_pc = '0; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_alu_out = '0;
            foreach (m_rf[i]) m_rf[i] = '0;
        end else begin
            rd = m_ir[25:21];
            rs = m_ir[20:16];
            pb = c.rfb ? rd : m_ir[15:11];
            va = rf_rd(rs);
            vb = rf_rd(pb);
            wdat = c.wd ? m_mdr : m_alu_out;
            if (c.pc_w || (c.pc_beq && res == 32'h0)) m_pc = c.pcsrc ? m_alu_out[7:0] : res[7:0];
            if (c.aluout_w) m_alu_out = res;
            if (c.ir_w) m_ir = rdata;
            if (c.mdr_w) m_mdr = rdata;
            if (c.a_w) m_a = va;
            if (c.b_w) m_b = vb;
`ifdef MC_DP_R0_ZERO_EN
            if (c.rf_w && rd != 5'd0) m_rf[rd] = wdat;
`else
            if (c.rf_w) m_rf[rd] = wdat;
`endif
        end
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr);
        ctrl_t c = '0;
        c.ir_w = 1'b1; c.alua = 1'b1; c.alub = 2'd1; c.aluop = OP_ADD; c.pc_w = 1'b1;
        tick(c, instr, 1'b0);
    endtask

    // Loads A/B and precomputes the branch target PC + sext(imm) into ALUOut.
    task automatic decode(input logic rfb);
        ctrl_t c = '0;
        c.a_w = 1'b1; c.b_w = 1'b1; c.rfb = rfb;
        c.aluout_w = 1'b1; c.alua = 1'b1; c.alub = 2'd2; c.aluop = OP_ADD;
        tick(c, 32'h0, 1'b0);
    endtask

    task automatic execute(input logic [1:0] alub, input logic [5:0] aluop);
        ctrl_t c = '0;
        c.aluout_w = 1'b1; c.alub = alub; c.aluop = aluop;
        tick(c, 32'h0, 1'b0);
    endtask

    task automatic writeback(input logic wd);
        ctrl_t c = '0;
        c.rf_w = 1'b1; c.wd = wd;
        tick(c, 32'h0, 1'b0);
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] val);
        ctrl_t c = '0;
        c.ir_w = 1'b1;
        tick(c, mk_r(6'h0, r, 5'd0, 5'd0), 1'b0);
        c = '0; c.mdr_w = 1'b1;
        tick(c, val, 1'b0);
        writeback(1'b1);
    endtask

    task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string name);
        ctrl_t c = '0;
        c.ir_w = 1'b1;
        tick(c, mk_r(6'h0, 5'd0, 5'd0, r), 1'b0);
        c = '0; c.b_w = 1'b1;
        tick(c, 32'h0, 1'b0);
        check(name, bus.mem_wdata, exp);
    endtask

    task automatic do_reset();
        tick('0, 32'h0, 1'b1);
    endtask

    vec_t        vt [13];
    ctrl_t       c;
    logic [31:0] r0_exp;
    logic [5:0]  ops [10] = '{6'h10, 6'h12, 6'h13, 6'h14, 6'h15, 6'h20, 6'h32, 6'h39, 6'h3B, 6'h3C};

    initial begin
        vt[0]  = '{6'h12, 32'd5,          32'd7,          32'd12};
        vt[1]  = '{6'h13, 32'd5,          32'd7,          32'hFFFF_FFFE};
        vt[2]  = '{6'h14, 32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F};
        vt[3]  = '{6'h15, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00};
        vt[4]  = '{6'h10, 32'h1234_5678,  32'h9,          32'h1234_5678};
        vt[5]  = '{6'h39, 32'h1,          32'hCAFE_BABE,  32'hCAFE_BABE};
        vt[6]  = '{6'h3B, 32'hFFFF_FFFF,  32'h1,          32'h0};
        vt[7]  = '{6'h3C, 32'h8000_0000,  32'h8000_0000,  32'h0};
        vt[8]  = '{6'h20, 32'h55,         32'h55,         32'h0};
        vt[9]  = '{6'h07, 32'h1234,       32'h4321,       32'h0};
        vt[10] = '{6'h32, 32'd3,          32'd4,          32'd7};
        vt[11] = '{6'h01, 32'h1,          32'h1,          32'h0};
        vt[12] = '{6'h30, 32'hDEAD_BEEF,  32'h1,          32'hDEAD_BEEF};

        m_pc = '0; m_ir = '0; m_mdr = '0; m_a = '0; m_b = '0; m_alu_out = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        reset = 1'b1;
        drive('0);
        bus.mem_rdata = '0;
        #1;

        // Reset state
        do_reset();
        do_reset();
        check("rst_opcode", {26'h0, OP_Code}, 32'h0);
        check("rst_addr",   {24'h0, bus.mem_addr}, 32'h0);
        check("rst_wdata",  bus.mem_wdata, 32'h0);
        check("rst_zero",   {31'h0, zero}, 32'h1);

        // Reset mid-fetch with dirty state and every strobe high
        write_reg(5'd7, 32'hA5A5_A5A5);
        fetch(32'hFFFF_FFFF);
        check("ir_all_ones", {26'h0, OP_Code}, 32'h3F);
        c = '1;
        tick(c, 32'h1234_5678, 1'b1);
        check("mid_rst_opcode", {26'h0, OP_Code}, 32'h0);
        check("mid_rst_wdata",  bus.mem_wdata, 32'h0);
        tick('0, 32'h0, 1'b0);
        check("mid_rst_pc",   {24'h0, bus.mem_addr}, 32'h0);
        check("mid_rst_zero", {31'h0, zero}, 32'h1);
        for (int r = 0; r < 32; r++) read_reg(5'(r), 32'h0, "rst_reg_clear");

        // Fetch of ADD r1,r2,r3
        do_reset();
        fetch(32'h4822_1800);
        check("fetch_pc",     {24'h0, bus.mem_addr}, 32'h1);
        check("fetch_opcode", {26'h0, OP_Code}, 32'h12);

        // Full ADD instruction
        write_reg(5'd2, 32'd5);
        write_reg(5'd3, 32'd7);
        fetch(32'h4822_1800);
        decode(1'b0);
        execute(2'd0, OP_ADD);
        writeback(1'b0);
        read_reg(5'd1, 32'd12, "add_r1");

        // LI r4, 0xFFFF then SWI r4 -> [r0 + 0x10]
        fetch(mk_i(OP_LI, 5'd4, 5'd0, 16'hFFFF));
        decode(1'b0);
        execute(2'd2, OP_LI);
        writeback(1'b0);
        fetch(mk_i(OP_SWI, 5'd4, 5'd0, 16'h0010));
        decode(1'b1);
        execute(2'd2, OP_SWI);
        c = '0; c.iord = 1'b1; c.mem_write = 1'b1;
        tick(c, 32'h0, 1'b0);
        check("swi_we",    {31'h0, bus.mem_we}, 32'h1);
        check("swi_addr",  {24'h0, bus.mem_addr}, 32'h10);
        check("swi_wdata", bus.mem_wdata, 32'hFFFF_FFFF);
        tick('0, 32'h0, 1'b0);
        check("swi_we_pulse", {31'h0, bus.mem_we}, 32'h0);

        // BEQ taken: rd=rs=3, imm=-2 at PC=5
        do_reset();
        write_reg(5'd3, 32'h0000_1234);
        for (int i = 0; i < 5; i++) fetch(32'h0);
        check("beq_start_pc", {24'h0, bus.mem_addr}, 32'h5);
        fetch(mk_i(OP_BEQ, 5'd3, 5'd3, 16'hFFFE));
        decode(1'b1);
        c = '0; c.pc_beq = 1'b1; c.pcsrc = 1'b1; c.aluop = OP_BEQ;
        tick(c, 32'h0, 1'b0);
        check("beq_taken_pc", {24'h0, bus.mem_addr}, 32'h4);

        // BEQ not taken
        do_reset();
        write_reg(5'd3, 32'h0000_1234);
        write_reg(5'd5, 32'h0000_1235);
        for (int i = 0; i < 5; i++) fetch(32'h0);
        fetch(mk_i(OP_BEQ, 5'd3, 5'd5, 16'hFFFE));
        decode(1'b1);
        c = '0; c.pc_beq = 1'b1; c.pcsrc = 1'b1; c.aluop = OP_BEQ;
        tick(c, 32'h0, 1'b0);
        check("beq_not_taken_pc", {24'h0, bus.mem_addr}, 32'h6);

        // LI r0, 9
        fetch(mk_i(OP_LI, 5'd0, 5'd0, 16'd9));
        decode(1'b0);
        execute(2'd2, OP_LI);
        writeback(1'b0);
`ifdef MC_DP_R0_ZERO_EN
        r0_exp = 32'h0;
`else
        r0_exp = 32'd9;
`endif
        read_reg(5'd0, r0_exp, "li_r0");

        // ALU vector table
        for (int i = 0; i < 13; i++) begin
            write_reg(5'd1, vt[i].a);
            write_reg(5'd2, vt[i].b);
            c = '0; c.ir_w = 1'b1;
            tick(c, mk_r(6'h0, 5'd5, 5'd1, 5'd2), 1'b0);
            c = '0; c.a_w = 1'b1; c.b_w = 1'b1;
            tick(c, 32'h0, 1'b0);
            execute(2'd0, vt[i].op);
            check("alu_zero", {31'h0, zero}, {31'h0, vt[i].exp == 32'h0});
            writeback(1'b0);
            read_reg(5'd5, vt[i].exp, "alu_vec");
        end

        // Randomized strobes against the model
        for (int n = 0; n < 400; n++) begin
            c.mem_write = 1'($urandom_range(0, 1));
            c.pc_w      = 1'($urandom_range(0, 3) == 0);
            c.pc_beq    = 1'($urandom_range(0, 1));
            c.ir_w      = 1'($urandom_range(0, 1));
            c.mdr_w     = 1'($urandom_range(0, 1));
            c.a_w       = 1'($urandom_range(0, 1));
            c.b_w       = 1'($urandom_range(0, 1));
            c.aluout_w  = 1'($urandom_range(0, 1));
            c.rf_w      = 1'($urandom_range(0, 1));
            c.iord      = 1'($urandom_range(0, 1));
            c.rfb       = 1'($urandom_range(0, 1));
            c.wd        = 1'($urandom_range(0, 1));
            c.alua      = 1'($urandom_range(0, 1));
            c.pcsrc     = 1'($urandom_range(0, 1));
            c.alub      = 2'($urandom_range(0, 3));
            c.aluop     = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
            tick(c, $urandom, 1'($urandom_range(0, 39) == 0));
        end
        for (int r = 0; r < 32; r++) read_reg(5'(r), rf_rd(5'(r)), "rand_reg_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
